// File: rtl/config_frame_writer_if.sv
// Word-port and frame-bus bundle for config_frame_writer.
// master = bitstream source / observer, slave = the writer itself.
interface config_frame_writer_if #(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLUMNS    = 8,
    parameter int unsigned FRAMES_PER_COL = 20
);
    logic [31:0]                             WriteData;
    logic                                    WriteStrobe;
    logic [32*NUM_ROWS-1:0]                  FrameData;
    logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]   FrameStrobe;
    logic                                    ConfigActive;
    logic                                    ConfigError;

    modport master (
        output WriteData, WriteStrobe,
        input  FrameData, FrameStrobe, ConfigActive, ConfigError
    );

    modport slave (
        input  WriteData, WriteStrobe,
        output FrameData, FrameStrobe, ConfigActive, ConfigError
    );
endinterface

// File: rtl/config_frame_writer.sv
// Turns a 32-bit configuration word stream into frame writes (FrameData + one-hot FrameStrobe).
// Optional feature: define CONFIG_WRITER_CHECK_EN to require an XOR check word per frame.
module config_frame_writer #(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLUMNS    = 8,
    parameter int unsigned FRAMES_PER_COL = 20
) (
    input logic                 CLK,
    input logic                 RESET,
    config_frame_writer_if.slave bus
);
    localparam int unsigned StrobeW = NUM_COLUMNS * FRAMES_PER_COL;
    localparam int unsigned IdxW    = (StrobeW > 1) ? $clog2(StrobeW) : 1;
    localparam int unsigned CntW    = $clog2(NUM_ROWS + 1);

    localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
    localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StHeader = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StSkip   = 3'd3;
`ifdef CONFIG_WRITER_CHECK_EN
    localparam logic [2:0] StCheck  = 3'd4;
    // A skipped frame still carries its check word.
    localparam logic [CntW-1:0] SkipLast = CntW'(NUM_ROWS);
`else
    localparam logic [CntW-1:0] SkipLast = CntW'(NUM_ROWS - 1);
`endif
    localparam logic [CntW-1:0] DataLast = CntW'(NUM_ROWS - 1);

    logic [2:0]               state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [32*NUM_ROWS-1:0]   data_q, data_d;
    logic [StrobeW-1:0]       strobe_q, strobe_d;
    logic                     err_q, err_d;
`ifdef CONFIG_WRITER_CHECK_EN
    logic [31:0]              chk_q, chk_d;
`endif

    logic [7:0] hdr_col;
    logic [7:0] hdr_frame;
    logic       hdr_ok;

    assign hdr_col   = bus.WriteData[15:8];
    assign hdr_frame = bus.WriteData[7:0];
    assign hdr_ok    = (32'(hdr_col) < NUM_COLUMNS) && (32'(hdr_frame) < FRAMES_PER_COL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        strobe_d = '0;
        err_d    = err_q;
`ifdef CONFIG_WRITER_CHECK_EN
        chk_d    = chk_q;
`endif
        if (bus.WriteStrobe) begin
            case (state_q)
                StIdle: begin
                    if (bus.WriteData == SyncWord) begin
                        state_d = StHeader;
                        err_d   = 1'b0;
                    end
                end
                StHeader: begin
                    if (bus.WriteData == DesyncWord) begin
                        state_d = StIdle;
                    end else if (bus.WriteData != SyncWord) begin
                        cnt_d = '0;
                        if (hdr_ok) begin
                            idx_d   = IdxW'(hdr_col) * IdxW'(FRAMES_PER_COL) + IdxW'(hdr_frame);
                            state_d = StData;
`ifdef CONFIG_WRITER_CHECK_EN
                            chk_d   = bus.WriteData;
`endif
                        end else begin
                            err_d   = 1'b1;
                            state_d = StSkip;
                        end
                    end
                end
                StData: begin
                    for (int k = 0; k < int'(NUM_ROWS); k++) begin
                        if (cnt_q == CntW'(k)) data_d[32*k +: 32] = bus.WriteData;
                    end
`ifdef CONFIG_WRITER_CHECK_EN
                    chk_d = chk_q ^ bus.WriteData;
`endif
                    if (cnt_q == DataLast) begin
`ifdef CONFIG_WRITER_CHECK_EN
                        state_d = StCheck;
`else
                        strobe_d = StrobeW'(1) << idx_q;
                        state_d  = StHeader;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef CONFIG_WRITER_CHECK_EN
                StCheck: begin
                    if (bus.WriteData == chk_q) strobe_d = StrobeW'(1) << idx_q;
                    else                        err_d    = 1'b1;
                    state_d = StHeader;
                end
`endif
                StSkip: begin
                    if (cnt_q == SkipLast) state_d = StHeader;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
`ifdef CONFIG_WRITER_CHECK_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
`ifdef CONFIG_WRITER_CHECK_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign bus.FrameData    = data_q;
    assign bus.FrameStrobe  = strobe_q;
    assign bus.ConfigActive = (state_q != StIdle);
    assign bus.ConfigError  = err_q;
endmodule
